// File: rtl/mrv1_th_sched_if.sv
// Issue handshake between the thread scheduler and the issue stage.
// The scheduler offers a thread id and the issue stage accepts it and qualifies the instruction.
interface mrv1_th_sched_if #(
  parameter int NUM_THREADS_P = 8
) ();
  localparam int tid_width_lp = $clog2(NUM_THREADS_P);

  logic                    issue_valid_o;
  logic [tid_width_lp-1:0] issue_tid_o;
  logic                    issue_ready_i;
  logic                    issue_ll_i;
  logic                    issue_sync_i;

  modport master (
    output issue_valid_o,
    output issue_tid_o,
    input  issue_ready_i,
    input  issue_ll_i,
    input  issue_sync_i
  );

  modport slave (
    input  issue_valid_o,
    input  issue_tid_o,
    output issue_ready_i,
    output issue_ll_i,
    output issue_sync_i
  );
endinterface

// File: rtl/mrv1_th_sched.sv
// Round-robin per-thread issue scheduler with pending-op throttling and drain.
// Optional MRV1_TH_SCHED_PRIO_EN adds a registered high-priority thread mask.
module mrv1_th_sched #(
  parameter  int NUM_THREADS_P = 8,
  parameter  int MAX_PEND_P    = 3,
  localparam int tid_width_lp  = $clog2(NUM_THREADS_P),
  localparam int cnt_width_lp  = $clog2(MAX_PEND_P + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_THREADS_P-1:0] spawn_i,
  input  logic [NUM_THREADS_P-1:0] kill_i,
`ifdef MRV1_TH_SCHED_PRIO_EN
  input  logic [NUM_THREADS_P-1:0] prio_i,
`endif
  mrv1_th_sched_if.master          issue_if,
  input  logic                     cmpl_valid_i,
  input  logic [tid_width_lp-1:0]  cmpl_tid_i,
  output logic [NUM_THREADS_P-1:0] active_o,
  output logic                     err_o
);

  typedef enum logic [1:0] {
    TH_OFF,
    TH_RUN,
    TH_DRAIN
  } th_state_e;

  th_state_e               state_q [NUM_THREADS_P];
  th_state_e               state_d [NUM_THREADS_P];
  logic [cnt_width_lp-1:0] pend_q  [NUM_THREADS_P];
  logic [cnt_width_lp-1:0] pend_d  [NUM_THREADS_P];
  logic [tid_width_lp-1:0] ptr_q, ptr_d;
  logic                    err_q, err_d;

  logic [NUM_THREADS_P-1:0] elig;
  logic [NUM_THREADS_P-1:0] cand;
  logic [NUM_THREADS_P-1:0] hs_v, inc_v, dec_v;
  logic                     sel_vld;
  logic [tid_width_lp-1:0]  sel_tid;
  logic                     hs;

`ifdef MRV1_TH_SCHED_PRIO_EN
  logic [NUM_THREADS_P-1:0] prio_q, prio_d;
  logic [NUM_THREADS_P-1:0] hi;

  always_comb begin
    prio_d = prio_i;
    hi     = elig & prio_q;
    cand   = (|hi) ? hi : elig;
  end
`else
  always_comb begin
    cand = elig;
  end
`endif

  // Selection uses registered state only, so the offer never depends on inputs
  always_comb begin
    elig    = '0;
    sel_vld = 1'b0;
    sel_tid = '0;
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      elig[t] = (state_q[t] == TH_RUN) &&
                (pend_q[t] < cnt_width_lp'(MAX_PEND_P));
    end
    for (int i = 0; i < NUM_THREADS_P; i++) begin
      if (!sel_vld && cand[ptr_q + tid_width_lp'(i)]) begin
        sel_vld = 1'b1;
        sel_tid = ptr_q + tid_width_lp'(i);
      end
    end
  end

  assign issue_if.issue_valid_o = sel_vld;
  assign issue_if.issue_tid_o   = sel_tid;
  assign hs = sel_vld & issue_if.issue_ready_i;

  always_comb begin
    hs_v  = '0;
    inc_v = '0;
    dec_v = '0;
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      hs_v[t]  = hs && (sel_tid == tid_width_lp'(t));
      inc_v[t] = hs_v[t] && issue_if.issue_ll_i && !kill_i[t];
      dec_v[t] = cmpl_valid_i && (cmpl_tid_i == tid_width_lp'(t)) &&
                 (state_q[t] != TH_OFF) && !kill_i[t];
    end
  end

  always_comb begin
    ptr_d = hs ? sel_tid + tid_width_lp'(1) : ptr_q;
    err_d = err_q;
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      state_d[t] = state_q[t];
      pend_d[t]  = pend_q[t];
      if (inc_v[t] && !dec_v[t]) begin
        pend_d[t] = pend_q[t] + cnt_width_lp'(1);
      end else if (dec_v[t] && !inc_v[t]) begin
        if (pend_q[t] == '0) err_d = 1'b1;
        else pend_d[t] = pend_q[t] - cnt_width_lp'(1);
      end
      unique case (state_q[t])
        TH_OFF:   if (spawn_i[t]) state_d[t] = TH_RUN;
        TH_RUN:   if (hs_v[t] && issue_if.issue_sync_i) state_d[t] = TH_DRAIN;
        TH_DRAIN: if (pend_q[t] == '0) state_d[t] = TH_RUN;
        default:  state_d[t] = TH_OFF;
      endcase
      if (kill_i[t]) begin
        state_d[t] = TH_OFF;
        pend_d[t]  = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        state_q[t] <= TH_OFF;
        pend_q[t]  <= '0;
      end
      ptr_q <= '0;
      err_q <= 1'b0;
`ifdef MRV1_TH_SCHED_PRIO_EN
      prio_q <= '0;
`endif
    end else begin
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        state_q[t] <= state_d[t];
        pend_q[t]  <= pend_d[t];
      end
      ptr_q <= ptr_d;
      err_q <= err_d;
`ifdef MRV1_TH_SCHED_PRIO_EN
      prio_q <= prio_d;
`endif
    end
  end

  always_comb begin
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      active_o[t] = (state_q[t] != TH_OFF);
    end
  end

  assign err_o = err_q;

endmodule

// File: doc/mrv1_th_sched.md
Name: mrv1_th_sched

Overview:
Per-thread issue scheduler for the multithreaded core. Holds a lifecycle state and a count of outstanding long-latency ops for each hardware thread. Each cycle it picks one eligible thread, round-robin, and presents it to the issue stage over a valid/ready handshake. Threads are throttled on outstanding-op limits and on drain (sync) instructions, and woken by writeback completions.

Parameters:
NUM_THREADS_P, 8, number of hardware threads (power of 2, ≥2)
MAX_PEND_P, 3, max outstanding long-latency ops per thread (1..15)
tid_width_lp, $clog2(NUM_THREADS_P), thread-id width (derived)
cnt_width_lp, $clog2(MAX_PEND_P+1), pending-counter width (derived)

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_ni  in  1  reset, synchronous, active-low
spawn_i  in  NUM_THREADS_P  per-thread start request (level, sampled each cycle)
kill_i  in  NUM_THREADS_P  per-thread stop request
issue_valid_o  out  1  an eligible thread is offered
issue_tid_o  out  tid_width_lp  offered thread id
issue_ready_i  in  1  issue stage accepts; handshake = valid & ready
issue_ll_i  in  1  accepted instr is long-latency (qualified by handshake)
issue_sync_i  in  1  accepted instr requires the thread's pending ops to drain
cmpl_valid_i  in  1  long-latency completion strobe
cmpl_tid_i  in  tid_width_lp  completing thread
active_o  out  NUM_THREADS_P  thread state != OFF
err_o  out  1  sticky: completion arrived for a RUN/DRAIN thread whose pend=0

Behaviour:
- Reset (rst_ni=0 at posedge): every thread goes to OFF with pend=0; RR pointer=0; err_o=0. While reset is held: issue_valid_o=0, issue_tid_o=0, active_o=0. Reset mid-operation discards all pending counts.
- Per-thread FSM states: OFF, RUN, DRAIN.
  - OFF → RUN on spawn_i[t]. pend is already 0 on entry.
  - RUN → DRAIN on a handshake for t with issue_sync_i=1.
  - DRAIN → RUN in the cycle after pend reaches 0. A DRAIN handshake with pend already 0 (net of a same-cycle completion) returns to RUN next cycle.
  - Any state → OFF on kill_i[t]; pend is cleared.
  - Priority: kill > spawn. spawn_i on a RUN or DRAIN thread is ignored.
- Eligibility: elig[t] = (state==RUN) & (pend<MAX_PEND_P). Eligibility is computed only from registered state, so issue_valid_o has no combinational path from any input.
- Arbitration:
  - Search for the first eligible thread starting at the RR pointer, wrapping modulo NUM_THREADS_P.
  - issue_valid_o = |elig. issue_tid_o = selected id, or 0 when not valid.
  - On handshake, the pointer becomes (tid+1) mod NUM_THREADS_P. Without a handshake the pointer and selection hold, so the offer stays stable while ready is low.
- Pending counter, per thread:
  - +1 on a handshake for t with issue_ll_i=1.
  - −1 on cmpl_valid_i with cmpl_tid_i==t.
  - Both in the same cycle: net unchanged.
  - Saturates at 0. A decrement at 0 leaves 0 and sets err_o when the thread is RUN or DRAIN.
  - Completions for OFF threads are ignored silently.
  - Never exceeds MAX_PEND_P, because a thread at MAX is not eligible.
- Same-cycle events on one thread: a kill wins over a handshake and a completion. The handshake still advances the RR pointer.
- Latency: a spawn at cycle n makes the thread eligible at n+1. A completion that frees a slot at n makes the thread eligible at n+1.
- Once set, err_o clears only on reset.

Optional Feature:
MRV1_TH_SCHED_PRIO_EN
- Defined: adds input prio_i [NUM_THREADS_P], a high-priority mask (registered internally, effective one cycle after change).
  - If any eligible thread has its registered prio bit set, selection is restricted to those threads, using the same shared RR pointer.
  - Otherwise selection is normal RR.
- Undefined: no prio_i port; pure round-robin.

Test Plan:
- Reset then spawn_i=8'h05, ready=1 always → active_o=8'h05 next cycle; grants alternate tid 0,2,0,2; issue_valid_o=0 before spawn.
- Thread 3 alone, issue_ll_i=1 on every handshake, MAX_PEND_P=3 → 3 grants, then issue_valid_o=0. One completion for tid 3 → valid again the next cycle, one grant, blocked again.
- Thread 1 with pend=2 issues with issue_sync_i=1 → DRAIN, no grants to 1. Two completions → RUN the cycle after pend=0, grants resume.
- issue_ready_i=0 for 5 cycles with threads 1,4,6 eligible → issue_tid_o held at the same id, pointer unchanged. Raise ready → order 1,4,6,1.
- Same cycle: kill_i[2]=1, spawn_i[2]=1, handshake on tid 2 → thread 2 OFF, pend=0. A later cmpl_tid_i=2 → err_o stays 0. A completion for a RUN thread with pend=0 → err_o=1 and stays 1.
- With MRV1_TH_SCHED_PRIO_EN, threads 0,5,7 eligible, prio_i=8'h80 → tid 7 granted every cycle until prio_i=0, then RR continues from 0.
